// File: rtl/mod_counter_if.sv
// Bus bundle for mod_counter: control strobes in, count/flags out.
// MOD_COUNTER_WRAPCNT_EN adds the 16-bit WrapCnt wrap tally.
interface mod_counter_if #(
  parameter int WIDTH = 6
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadVal;
  logic [WIDTH-1:0] Count;
  logic             Tc;
  logic             Wrap;
`ifdef MOD_COUNTER_WRAPCNT_EN
  logic [15:0]      WrapCnt;

  modport master (
    output En, Up, Load, LoadVal,
    input  Count, Tc, Wrap, WrapCnt
  );

  modport slave (
    input  En, Up, Load, LoadVal,
    output Count, Tc, Wrap, WrapCnt
  );
`else
  modport master (
    output En, Up, Load, LoadVal,
    input  Count, Tc, Wrap
  );

  modport slave (
    input  En, Up, Load, LoadVal,
    output Count, Tc, Wrap
  );
`endif
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter over [MIN_VAL, MAX_VAL] with clamped load, wrap pulse
// and optional saturation. MOD_COUNTER_WRAPCNT_EN adds the WrapCnt tally.
module mod_counter #(
  parameter int WIDTH    = 6,
  parameter int MIN_VAL  = 1,
  parameter int MAX_VAL  = 61,
  parameter int SATURATE = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  mod_counter_if.slave bus
);

  if ((MIN_VAL < 0) || (MIN_VAL >= MAX_VAL) || (MAX_VAL > ((2 ** WIDTH) - 1))) begin : g_bad_params
    $error("mod_counter: requires 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_V  = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_V  = MAX_VAL[WIDTH-1:0];
  localparam logic             SAT_EN = (SATURATE != 0);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic [WIDTH-1:0] next_count_s;
  logic             wrap_next_s;

  // Next-state decode: load (clamped) beats count; limits are compared before stepping.
  always_comb begin
    next_count_s = count_r;
    wrap_next_s  = 1'b0;
    if (bus.Load) begin
      if (bus.LoadVal > MAX_V) begin
        next_count_s = MAX_V;
      end else if (bus.LoadVal < MIN_V) begin
        next_count_s = MIN_V;
      end else begin
        next_count_s = bus.LoadVal;
      end
    end else if (bus.En) begin
      if (bus.Up) begin
        if (count_r < MAX_V) begin
          next_count_s = count_r + 1'b1;
        end else if (SAT_EN) begin
          next_count_s = MAX_V;
        end else begin
          next_count_s = MIN_V;
          wrap_next_s  = 1'b1;
        end
      end else begin
        if (count_r > MIN_V) begin
          next_count_s = count_r - 1'b1;
        end else if (SAT_EN) begin
          next_count_s = MIN_V;
        end else begin
          next_count_s = MAX_V;
          wrap_next_s  = 1'b1;
        end
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_r <= MIN_V;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= next_count_s;
      wrap_r  <= wrap_next_s;
    end
  end

  assign bus.Count = count_r;
  assign bus.Wrap  = wrap_r;
  assign bus.Tc    = (bus.Up && (count_r == MAX_V)) || (!bus.Up && (count_r == MIN_V));

`ifdef MOD_COUNTER_WRAPCNT_EN
  logic [15:0] wrap_cnt_r;

  // Free-running tally of wrap edges; rolls over naturally at 16 bits.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wrap_cnt_r <= 16'd0;
    end else if (wrap_next_s) begin
      wrap_cnt_r <= wrap_cnt_r + 16'd1;
    end else begin
      wrap_cnt_r <= wrap_cnt_r;
    end
  end

  assign bus.WrapCnt = wrap_cnt_r;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter: a wrapping instance and a
// saturating instance share clock and reset.
module tb_mod_counter;

  logic Clk;
  logic Reset;
  int   tests;
  int   fails;

  mod_counter_if #(.WIDTH(6)) bus_a ();
  mod_counter_if #(.WIDTH(6)) bus_b ();

  mod_counter #(.WIDTH(6), .MIN_VAL(1), .MAX_VAL(61), .SATURATE(0)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a.slave)
  );

  mod_counter #(.WIDTH(6), .MIN_VAL(1), .MAX_VAL(61), .SATURATE(1)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b0;
    bus_a.En = 1'b0; bus_a.Up = 1'b1; bus_a.Load = 1'b0; bus_a.LoadVal = 6'd0;
    bus_b.En = 1'b0; bus_b.Up = 1'b1; bus_b.Load = 1'b0; bus_b.LoadVal = 6'd0;

    // Reset state
    #12;
    chk("rst_count_a", bus_a.Count, 32'd1);
    chk("rst_wrap_a",  bus_a.Wrap,  32'd0);
    chk("rst_tc_up",   bus_a.Tc,    32'd0);
    chk("rst_count_b", bus_b.Count, 32'd1);
    bus_a.Up = 1'b0;
    #1;
    chk("rst_tc_down", bus_a.Tc, 32'd1);
    bus_a.Up = 1'b1;
`ifdef MOD_COUNTER_WRAPCNT_EN
    chk("rst_wrapcnt", bus_a.WrapCnt, 32'd0);
`endif

    // Full up sweep 1..61 then wrap to 1
    @(negedge Clk);
    Reset = 1'b1;
    bus_a.En = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk("up_count", bus_a.Count, 32'(k + 1));
      chk("up_tc",    bus_a.Tc,    (k == 60) ? 32'd1 : 32'd0);
      chk("up_wrap",  bus_a.Wrap,  32'd0);
    end
    tick();
    chk("upwrap_count", bus_a.Count, 32'd1);
    chk("upwrap_pulse", bus_a.Wrap,  32'd1);
    tick();
    chk("upwrap_next",  bus_a.Count, 32'd2);
    chk("upwrap_clear", bus_a.Wrap,  32'd0);

    // Hold with En=0
    bus_a.En = 1'b0;
    tick();
    tick();
    chk("hold_count", bus_a.Count, 32'd2);

    // Down wrap from MIN_VAL
    bus_a.Load = 1'b1; bus_a.LoadVal = 6'd1;
    tick();
    chk("ld1_count", bus_a.Count, 32'd1);
    bus_a.Load = 1'b0; bus_a.Up = 1'b0;
    #1;
    chk("dn_tc_min", bus_a.Tc, 32'd1);
    bus_a.En = 1'b1;
    tick();
    chk("dnwrap_count", bus_a.Count, 32'd61);
    chk("dnwrap_pulse", bus_a.Wrap,  32'd1);
    chk("dnwrap_tc",    bus_a.Tc,    32'd0);
    tick();
    chk("dn_count", bus_a.Count, 32'd60);
    chk("dn_wrap",  bus_a.Wrap,  32'd0);

    // Clamped loads and load priority
    bus_a.En = 1'b0; bus_a.Load = 1'b1; bus_a.LoadVal = 6'd63;
    tick();
    chk("ld63_count", bus_a.Count, 32'd61);
    chk("ld63_wrap",  bus_a.Wrap,  32'd0);
    bus_a.LoadVal = 6'd0;
    tick();
    chk("ld0_count", bus_a.Count, 32'd1);
    bus_a.En = 1'b1; bus_a.Up = 1'b1; bus_a.LoadVal = 6'd30;
    tick();
    chk("ld30_count", bus_a.Count, 32'd30);
    chk("ld30_wrap",  bus_a.Wrap,  32'd0);

    // Repeated loads to MAX_VAL followed by wraps
    for (int r = 0; r < 2; r++) begin
      bus_a.Load = 1'b1; bus_a.LoadVal = 6'd61;
      tick();
      chk("rep_ld_count", bus_a.Count, 32'd61);
      chk("rep_ld_wrap",  bus_a.Wrap,  32'd0);
      bus_a.Load = 1'b0;
      tick();
      chk("rep_wr_count", bus_a.Count, 32'd1);
      chk("rep_wr_wrap",  bus_a.Wrap,  32'd1);
    end

    // Reset mid-operation, asserted between edges just after a wrap
    bus_a.Up = 1'b0;
    tick();
    chk("pre_rst_count", bus_a.Count, 32'd61);
    chk("pre_rst_wrap",  bus_a.Wrap,  32'd1);
    #3;
    Reset = 1'b0;
    #1;
    chk("mid_rst_count", bus_a.Count, 32'd1);
    chk("mid_rst_wrap",  bus_a.Wrap,  32'd0);
`ifdef MOD_COUNTER_WRAPCNT_EN
    chk("mid_rst_wrapcnt", bus_a.WrapCnt, 32'd0);
`endif
    tick();
    chk("in_rst_count", bus_a.Count, 32'd1);
    bus_a.Up = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    chk("post_rst_count", bus_a.Count, 32'd2);

    // Saturating instance holds at both limits
    bus_b.Load = 1'b1; bus_b.LoadVal = 6'd61; bus_b.Up = 1'b1; bus_b.En = 1'b1;
    tick();
    chk("sat_ld_count", bus_b.Count, 32'd61);
    bus_b.Load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_up_count", bus_b.Count, 32'd61);
      chk("sat_up_wrap",  bus_b.Wrap,  32'd0);
    end
    chk("sat_tc", bus_b.Tc, 32'd1);
    bus_b.Load = 1'b1; bus_b.LoadVal = 6'd1; bus_b.Up = 1'b0;
    tick();
    bus_b.Load = 1'b0;
    tick();
    tick();
    chk("sat_dn_count", bus_b.Count, 32'd1);
    chk("sat_dn_wrap",  bus_b.Wrap,  32'd0);

`ifdef MOD_COUNTER_WRAPCNT_EN
    // Three full up-wraps, then reset clears the tally
    bus_a.Load = 1'b1; bus_a.LoadVal = 6'd1; bus_a.Up = 1'b1; bus_a.En = 1'b1;
    tick();
    bus_a.Load = 1'b0;
    chk("wc_before", bus_a.WrapCnt, 32'd0);
    repeat (183) tick();
    chk("wc_count", bus_a.Count,   32'd1);
    chk("wc_three", bus_a.WrapCnt, 32'd3);
    Reset = 1'b0;
    #1;
    chk("wc_reset", bus_a.WrapCnt, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
